// File: rtl/uart_rx_8n1_if.sv
// Byte handshake between the UART receiver and its on-chip consumer.
// The receiver drives the byte and its valid flag.
// The consumer answers with ready.
interface uart_rx_8n1_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Each received byte goes into a single-entry valid/ready holding register.
// A low stop bit is reported as a framing error; a byte that arrives while
// the holding register is still full is dropped and flagged as an overrun.
module uart_rx_8n1 #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rxd,
  uart_rx_8n1_if.master rx_if,
  output logic          framing_err,
  output logic          overrun,
  input  logic          clr_err,
  output logic          busy
);

  localparam int DIV = CLK_HZ / (16 * BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_rx_8n1: CLK_HZ/(16*BAUD) must be at least 2");
    end
  endgenerate

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          sync1_q, sync2_q;
  logic          rxs;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          tick;
  logic          stop_tick;
  logic          deliver;

  assign rxs  = sync2_q;
  assign tick = (tick_cnt_q == TW'(DIV - 1));

  // Two-flop synchroniser; both stages idle high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM with tick, sample and bit counters; the tick phase restarts on the start edge
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    samp_d     = tick ? samp_q + 4'd1 : samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    stop_tick  = 1'b0;
    case (state_q)
      S_IDLE: begin
        samp_d = '0;
        if (!rxs) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick && samp_q == 4'd7) begin
          samp_d  = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && samp_q == 4'd15) begin
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick && samp_q == 4'd15) begin
          stop_tick = 1'b1;
          state_d   = rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign deliver = stop_tick && rxs;

  // Control state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
    end
  end

  // Data shift register; every bit is rewritten by each frame, so no reset is needed
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Holding register, framing pulse and sticky overrun; a delivery beats a plain handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= stop_tick && !rxs;
      if (deliver && (!valid_q || rx_if.rx_ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
      if (deliver && valid_q && !rx_if.rx_ready) begin
        ovr_q <= 1'b1;
      end else if (clr_err) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign framing_err    = ferr_q;
  assign overrun        = ovr_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial 8N1 receiver that deserialises an asynchronous UART line into bytes for the Tiger SOPC side of the board. It sits between the board's UART_RXD pin and any on-chip consumer, such as a program loader or debug monitor. It is the receiving end of the same 8N1 link driven by the system UART's transmitter. It oversamples the line at 16x, validates start and stop bits, and presents each byte through a single-entry valid/ready holding register with framing and overrun reporting.

## Interface
- CLK_HZ, 50000000, clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- DIV (localparam), CLK_HZ/(16*BAUD) truncated, clocks per oversample tick; the default gives 27; elaboration error if DIV < 2

- clk  in  1  system clock (CLOCK_50i domain)
- reset_n  in  1  asynchronous active-low reset
- rxd  in  1  serial line, idle high, asynchronous to clk
- rx_data  out  8  received byte, valid while rx_valid=1
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
- framing_err  out  1  one-cycle pulse, stop bit sampled low
- overrun  out  1  sticky, byte dropped because holding register full
- clr_err  in  1  synchronous clear of overrun
- busy  out  1  FSM not in IDLE

## Operation
- rxd passes through a 2-flop synchroniser; both flops reset to 1. rxs is the synchronised value.
- Tick counter runs 0..DIV-1 and ticks at DIV-1. It is cleared on the IDLE->START transition so the sample phase aligns to the detected edge.
- Sample counter is 4 bits wide and counts ticks; bit counter is 3 bits wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rxs=0 -> START, with tick and sample counters cleared.
  - START: on the 8th tick (mid start bit), rxs=0 -> DATA with the sample counter cleared; rxs=1 -> IDLE (glitch rejected, nothing reported).
  - DATA: every 16th tick, sample rxs into the shift register LSB first. After bit 7 -> STOP.
  - STOP: on the 16th tick, rxs=1 -> deliver byte, -> IDLE. rxs=0 -> pulse framing_err, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH: rxs=1 -> IDLE (no restart on a held-low/break line).
- Delivery:
  - If the holding register is empty, or rx_ready=1 in the delivery cycle: load rx_data and hold rx_valid=1.
  - Otherwise keep the old byte, drop the new one, and set overrun.
- rx_valid & rx_ready with no delivery in the same cycle: rx_valid -> 0 next cycle; rx_data holds its last value.
- overrun clears only on clr_err. If clr_err and a new overrun coincide, overrun stays set.
- Reset, including mid-frame: FSM -> IDLE, all counters 0, rx_data=0x00, rx_valid=0, framing_err=0, overrun=0, busy=0, synchroniser=1.

## Timing
- Edge detection: 2-3 clk after the line falls (synchroniser).
- Start validation: 8*DIV clk after START entry.
- Delivery: rx_valid rises 1 clk after the stop-sample tick, i.e. (8+16*9)*DIV+1 = 152*DIV+1 clk after START entry. With the default DIV=27 this is 4105 clk.
- framing_err is high for exactly the 1 clk after the stop-sample tick.
- busy is high from the cycle after START entry until the FSM returns to IDLE.
- Back-to-back frames are received with no idle gap; the FSM re-arms in IDLE during the second half of the stop bit.
- Baud error tolerance is determined by mid-bit sampling; DIV truncation error at the default settings is 0.5%.

## Test plan
Bench parameters: CLK_HZ=3200, BAUD=100, so DIV=2 and one bit = 32 clk.

- Frame 0xA5 with rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk, 305 clk after START entry; no framing_err or overrun.
- rxd low for 10 clk, then high -> START rejected, FSM back in IDLE, no rx_valid or framing_err; a following 0x5A frame is received correctly.
- Frame 0x3C with stop bit 0, line held low 100 clk then high -> single framing_err pulse, no rx_valid, FSM stays in WAIT_HIGH until the line is high; the next frame 0x81 is received.
- Frames 0x11, 0x22, 0x33 back-to-back with rx_ready=0 -> rx_data=0x11, rx_valid=1, overrun=1. After clr_err -> overrun=0, rx_data still 0x11.
- rx_valid=1 (0x11) with rx_ready pulsed in the exact delivery cycle of 0x22 -> rx_data=0x22, rx_valid stays 1, overrun=0.
- reset_n asserted during data bit 4 of 0xF0 -> all outputs 0 immediately; after release, a full 0x96 frame is received correctly.
